// File: rtl/simon_pkg.sv
// Shared Simon definitions: playback sequencer state encoding and LED mode constants
// shared with the top-level controller.
package simon_pkg;

  localparam int unsigned PB_STATE_W = 3;
  localparam int unsigned LED_MODE_W = 2;

  typedef enum logic [PB_STATE_W-1:0] {
    PB_IDLE   = 3'd0,
    PB_FETCH  = 3'd1,
    PB_SHOW   = 3'd2,
    PB_GAP    = 3'd3,
    PB_FINISH = 3'd4
  } pb_state_e;

  typedef enum logic [LED_MODE_W-1:0] {
    LED_OFF      = 2'd0,
    LED_PLAYBACK = 2'd1,
    LED_PLAYER   = 2'd2,
    LED_FAIL     = 2'd3
  } led_mode_e;

  function automatic logic pb_is_busy(input pb_state_e s);
    return (s != PB_IDLE);
  endfunction

endpackage

// File: rtl/simon_down_counter.sv
// Loadable down-counter that saturates at zero; zero flags the terminal count.
module simon_down_counter #(
  parameter int unsigned CNT_W = 25
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic             zero
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= load_val;
    end else if (en && (r_count != '0)) begin
      r_count <= r_count - CNT_W'(1);
    end
  end

  assign zero = (r_count == '0);

endmodule

// File: rtl/simon_playback_sequencer.sv
// Steps pattern memory readback for Simon playback: fetch, hold on display, blank gap,
// repeat up to the latched last address, then pulse done.
module simon_playback_sequencer
  import simon_pkg::*;
#(
  parameter int unsigned ADDR_W      = 6,
  parameter int unsigned CNT_W       = 25,
  parameter int unsigned HOLD_CYCLES = 25000000,
  parameter int unsigned GAP_CYCLES  = 12500000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] last_addr,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              rd_en,
  output logic              show,
  output logic              busy,
  output logic              done
);

  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);

  pb_state_e         r_state;
  pb_state_e         w_state_next;
  logic [ADDR_W-1:0] r_rd_addr;
  logic [ADDR_W-1:0] w_rd_addr_next;
  logic [ADDR_W-1:0] r_last_q;
  logic [ADDR_W-1:0] w_last_next;
  logic              w_tmr_load;
  logic [CNT_W-1:0]  w_tmr_load_val;
  logic              w_tmr_en;
  logic              w_tmr_zero;

  simon_down_counter #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (w_tmr_load),
    .load_val (w_tmr_load_val),
    .en       (w_tmr_en),
    .zero     (w_tmr_zero)
  );

  // Next-state, register-next and Moore output decode
  always_comb begin
    w_state_next   = r_state;
    w_rd_addr_next = r_rd_addr;
    w_last_next    = r_last_q;
    w_tmr_load     = 1'b0;
    w_tmr_load_val = '0;
    w_tmr_en       = 1'b0;
    rd_en          = 1'b0;
    show           = 1'b0;
    done           = 1'b0;
    busy           = pb_is_busy(r_state);

    case (r_state)
      PB_IDLE: begin
        if (start && !abort) begin
          w_state_next   = PB_FETCH;
          w_rd_addr_next = '0;
          w_last_next    = last_addr;
        end
      end
      PB_FETCH: begin
        rd_en          = 1'b1;
        w_tmr_load     = 1'b1;
        w_tmr_load_val = HOLD_LOAD;
        w_state_next   = PB_SHOW;
      end
      PB_SHOW: begin
        show     = 1'b1;
        w_tmr_en = 1'b1;
        if (w_tmr_zero) begin
          if (r_rd_addr == r_last_q) begin
            w_state_next = PB_FINISH;
          end else begin
            w_state_next   = PB_GAP;
            w_tmr_load     = 1'b1;
            w_tmr_load_val = GAP_LOAD;
          end
        end
      end
      PB_GAP: begin
        w_tmr_en = 1'b1;
        if (w_tmr_zero) begin
          w_state_next   = PB_FETCH;
          w_rd_addr_next = r_rd_addr + ADDR_W'(1);
        end
      end
      PB_FINISH: begin
        done         = 1'b1;
        w_state_next = PB_IDLE;
      end
      default: begin
        w_state_next = PB_IDLE;
      end
    endcase

    // Abort overrides every transition and freezes the read address
    if (abort && (r_state != PB_IDLE)) begin
      w_state_next   = PB_IDLE;
      w_rd_addr_next = r_rd_addr;
      w_tmr_load     = 1'b0;
      w_tmr_en       = 1'b0;
    end
  end

  // State, read address and last-entry registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= PB_IDLE;
      r_rd_addr <= '0;
      r_last_q  <= '0;
    end else begin
      r_state   <= w_state_next;
      r_rd_addr <= w_rd_addr_next;
      r_last_q  <= w_last_next;
    end
  end

  assign rd_addr = r_rd_addr;

endmodule

// File: tb/tb_simon_playback_sequencer.sv
// Scoreboard bench for simon_playback_sequencer with short HOLD/GAP timing.
module tb_simon_playback_sequencer;

  localparam int unsigned ADDR_W = 3;
  localparam int unsigned CNT_W  = 3;
  localparam int EV_FETCH = 0;
  localparam int EV_SHOW  = 1;
  localparam int EV_DONE  = 2;

  typedef struct {
    int kind;
    int cyc;
    int addr;
  } ev_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic [ADDR_W-1:0] last_addr = '0;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_en;
  logic              show;
  logic              busy;
  logic              done;

  ev_t exp_q[$];
  int  n_checks = 0;
  int  n_errors = 0;
  int  cyc = 0;
  int  t0 = 0;
  bit  show_d = 1'b0;

  simon_playback_sequencer #(
    .ADDR_W      (ADDR_W),
    .CNT_W       (CNT_W),
    .HOLD_CYCLES (4),
    .GAP_CYCLES  (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .last_addr (last_addr),
    .rd_addr   (rd_addr),
    .rd_en     (rd_en),
    .show      (show),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_ev(input int kind, input int c, input int addr);
    ev_t e;
    e.kind = kind;
    e.cyc  = c;
    e.addr = addr;
    exp_q.push_back(e);
  endtask

  task automatic sb_pop(input int kind);
    ev_t e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL unexpected_event: kind %0d at cycle %0d addr %0d, none expected",
               kind, cyc - t0, rd_addr);
    end else begin
      e = exp_q.pop_front();
      chk("event_kind", kind, e.kind);
      chk("event_cycle", cyc - t0, e.cyc);
      chk("event_addr", int'(rd_addr), e.addr);
    end
  endtask

  // Monitor: pops one expected event per observed fetch, show-rise or done
  always @(negedge clk) begin
    if (rst) begin
      show_d = 1'b0;
    end else begin
      if (rd_en) sb_pop(EV_FETCH);
      if (show && !show_d) sb_pop(EV_SHOW);
      if (done) sb_pop(EV_DONE);
      show_d = show;
    end
  end

  task automatic kick(input int la, input bit hold);
    @(negedge clk);
    last_addr = ADDR_W'(la);
    start     = 1'b1;
    t0        = cyc;
    if (!hold) begin
      @(negedge clk);
      start = 1'b0;
    end
  endtask

  task automatic drain(input string name);
    chk({name, "_pending"}, exp_q.size(), 0);
    chk({name, "_busy"}, int'(busy), 0);
    exp_q.delete();
  endtask

  task automatic check_idle_outputs(input string name);
    chk({name, "_rd_en"}, int'(rd_en), 0);
    chk({name, "_show"}, int'(show), 0);
    chk({name, "_busy"}, int'(busy), 0);
    chk({name, "_done"}, int'(done), 0);
  endtask

  task automatic scen_single();
    push_ev(EV_FETCH, 1, 0);
    push_ev(EV_SHOW, 2, 0);
    push_ev(EV_DONE, 6, 0);
    kick(0, 1'b0);
    repeat (12) @(negedge clk);
    drain("single");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    check_idle_outputs("reset");
    chk("reset_rd_addr", int'(rd_addr), 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // 1: single entry, no gap
    scen_single();

    // 2: three entries; last_addr changed after acceptance must not matter
    push_ev(EV_FETCH, 1, 0);  push_ev(EV_SHOW, 2, 0);
    push_ev(EV_FETCH, 8, 1);  push_ev(EV_SHOW, 9, 1);
    push_ev(EV_FETCH, 15, 2); push_ev(EV_SHOW, 16, 2);
    push_ev(EV_DONE, 20, 2);
    kick(2, 1'b0);
    last_addr = 3'd5;
    repeat (25) @(negedge clk);
    drain("three");

    // 3: start held high; re-accepted only after done
    push_ev(EV_FETCH, 1, 0);  push_ev(EV_SHOW, 2, 0);
    push_ev(EV_FETCH, 8, 1);  push_ev(EV_SHOW, 9, 1);
    push_ev(EV_DONE, 13, 1);
    push_ev(EV_FETCH, 15, 0); push_ev(EV_SHOW, 16, 0);
    push_ev(EV_FETCH, 22, 1); push_ev(EV_SHOW, 23, 1);
    push_ev(EV_DONE, 27, 1);
    kick(1, 1'b1);
    repeat (15) @(negedge clk);
    start = 1'b0;
    repeat (16) @(negedge clk);
    drain("held_start");

    // 4: abort during the second entry's show
    push_ev(EV_FETCH, 1, 0); push_ev(EV_SHOW, 2, 0);
    push_ev(EV_FETCH, 8, 1); push_ev(EV_SHOW, 9, 1);
    kick(2, 1'b0);
    repeat (9) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_cycle", cyc - t0, 11);
    chk("abort_busy", int'(busy), 0);
    chk("abort_show", int'(show), 0);
    chk("abort_rd_addr", int'(rd_addr), 1);
    repeat (20) @(negedge clk);
    chk("abort_rd_addr_hold", int'(rd_addr), 1);
    drain("abort");

    // 5: asynchronous reset mid-show, then a clean single-entry run
    push_ev(EV_FETCH, 1, 0); push_ev(EV_SHOW, 2, 0);
    kick(0, 1'b0);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_idle_outputs("async_rst");
    chk("async_rst_rd_addr", int'(rd_addr), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    drain("async_rst");
    scen_single();

    // 6: maximum last_addr; address stops at 7, done at cycle 55
    for (int i = 0; i < 8; i++) begin
      push_ev(EV_FETCH, 1 + 7 * i, i);
      push_ev(EV_SHOW, 2 + 7 * i, i);
    end
    push_ev(EV_DONE, 55, 7);
    kick(7, 1'b0);
    repeat (65) @(negedge clk);
    chk("max_rd_addr_final", int'(rd_addr), 7);
    drain("max");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
